pipeline_ctrl: RTL and testbench

Central hazard and redirect controller for the 3-stage core (IF/ID/EX plus the MEM interface). It owns the fetch PC register and generates per-stage stall and flush controls. Inputs come from the execution stage (taken branch or jump and its target, exceptions, MRET), from decode (source registers) and from the memory handshakes (imem ready, dmem busy). It sequences trap entry with the CSR file and holds a pending redirect while an instruction fetch is in flight.

---
 rtl/core_pkg.sv | 15 +
 rtl/pipeline_ctrl_if.sv | 46 ++++
 rtl/hazard_detect.sv | 25 ++
 rtl/pipeline_ctrl.sv | 135 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core-wide constants and the pipeline controller state encoding.
package core_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [XLEN-1:0] RESET_ADDR_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StTrap      = 2'd1,
    StWaitRedir = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Signal bundle between the core datapath (master) and the pipeline controller (slave).
interface pipeline_ctrl_if;
    import core_pkg::*;

    logic                  if_ready_i;
    logic                  mem_busy_i;
    logic [REG_ADDR_W-1:0] id_rs1_i;
    logic [REG_ADDR_W-1:0] id_rs2_i;
    logic                  id_uses_rs1_i;
    logic                  id_uses_rs2_i;
    logic                  ex_valid_i;
    logic [REG_ADDR_W-1:0] ex_rd_i;
    logic                  ex_is_load_i;
    logic                  ex_br_j_taken_i;
    logic [XLEN-1:0]       ex_br_j_addr_i;
    logic                  ex_exception_i;
    logic                  ex_is_mret_i;
    logic [XLEN-1:0]       csr_mtvec_i;
    logic [XLEN-1:0]       csr_mepc_i;

    logic [XLEN-1:0]       pc_o;
    logic                  trap_take_o;
    logic                  if_stall_o;
    logic                  id_stall_o;
    logic                  ex_stall_o;
    logic                  id_flush_o;
    logic                  ex_flush_o;
    logic [1:0]            state_o;

    modport master (
        output if_ready_i, mem_busy_i, id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
               ex_valid_i, ex_rd_i, ex_is_load_i, ex_br_j_taken_i, ex_br_j_addr_i,
               ex_exception_i, ex_is_mret_i, csr_mtvec_i, csr_mepc_i,
        input  pc_o, trap_take_o, if_stall_o, id_stall_o, ex_stall_o, id_flush_o,
               ex_flush_o, state_o
    );

    modport slave (
        input  if_ready_i, mem_busy_i, id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
               ex_valid_i, ex_rd_i, ex_is_load_i, ex_br_j_taken_i, ex_br_j_addr_i,
               ex_exception_i, ex_is_mret_i, csr_mtvec_i, csr_mepc_i,
        output pc_o, trap_take_o, if_stall_o, id_stall_o, ex_stall_o, id_flush_o,
               ex_flush_o, state_o
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the decode-stage sources and a load in EX.
module hazard_detect
    import core_pkg::*;
(
    input  logic                  ex_valid,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    output logic                  load_use
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
        rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
        // x0 is never a real dependency
        load_use = ex_valid && ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Fetch PC owner and stall/flush/trap sequencer for the IF/ID/EX pipeline.
module pipeline_ctrl
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_ADDR      = RESET_ADDR_DEFAULT,
    parameter logic [XLEN-1:0] TRAP_ALIGN_MASK = 32'hFFFF_FFFC
) (
    input  logic           clk_i,
    input  logic           rst_i,
    pipeline_ctrl_if.slave bus
);

    ctrl_state_e     state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] redir_q, redir_d;
    logic            pend_q, pend_d;

    logic            load_use;
    logic            redirect;
    logic [XLEN-1:0] redir_target;
    logic            if_stall, id_stall, ex_stall, id_flush, ex_flush, trap_take;

    hazard_detect u_hazard_detect (
        .ex_valid    (bus.ex_valid_i),
        .ex_is_load  (bus.ex_is_load_i),
        .ex_rd       (bus.ex_rd_i),
        .id_rs1      (bus.id_rs1_i),
        .id_rs2      (bus.id_rs2_i),
        .id_uses_rs1 (bus.id_uses_rs1_i),
        .id_uses_rs2 (bus.id_uses_rs2_i),
        .load_use    (load_use)
    );

    // Exceptions take the trap path, so only MRET vs branch decides the redirect target here
    assign redirect     = bus.ex_is_mret_i || bus.ex_br_j_taken_i;
    assign redir_target = bus.ex_is_mret_i ? bus.csr_mepc_i : bus.ex_br_j_addr_i;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        redir_d   = redir_q;
        pend_d    = pend_q;
        if_stall  = 1'b0;
        id_stall  = 1'b0;
        ex_stall  = 1'b0;
        id_flush  = 1'b0;
        ex_flush  = 1'b0;
        trap_take = 1'b0;

        unique case (state_q)
            StRun: begin
                if (bus.mem_busy_i) begin
                    if_stall = 1'b1;
                    id_stall = 1'b1;
                    ex_stall = 1'b1;
                end else if (bus.ex_exception_i && bus.ex_valid_i) begin
                    trap_take = 1'b1;
                    id_flush  = 1'b1;
                    ex_flush  = 1'b1;
                    state_d   = StTrap;
                    if (!bus.if_ready_i) pend_d = 1'b1;
                end else if (redirect) begin
                    id_flush = 1'b1;
                    ex_flush = 1'b1;
                    if (bus.if_ready_i) begin
                        pc_d = redir_target;
                    end else begin
                        // Fetch still in flight: park the target until it returns
                        redir_d  = redir_target;
                        pend_d   = 1'b1;
                        if_stall = 1'b1;
                        state_d  = StWaitRedir;
                    end
                end else if (load_use) begin
                    if_stall = 1'b1;
                    id_stall = 1'b1;
                    ex_flush = 1'b1;
                end else if (!bus.if_ready_i) begin
                    if_stall = 1'b1;
                    id_flush = 1'b1;
                end else begin
                    pc_d = pc_q + XLEN'(4);
                end
            end
            StTrap: begin
                id_flush = 1'b1;
                ex_flush = 1'b1;
                if (pend_q && !bus.if_ready_i) begin
                    if_stall = 1'b1;
                end else begin
                    pc_d    = bus.csr_mtvec_i & TRAP_ALIGN_MASK;
                    pend_d  = 1'b0;
                    state_d = StRun;
                end
            end
            StWaitRedir: begin
                id_flush = 1'b1;
                if (!bus.if_ready_i) begin
                    if_stall = 1'b1;
                end else begin
                    pc_d    = redir_q;
                    pend_d  = 1'b0;
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StRun;
            pc_q    <= RESET_ADDR;
            redir_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            redir_q <= redir_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        bus.pc_o        = pc_q;
        bus.state_o     = state_q;
        bus.trap_take_o = trap_take;
        bus.if_stall_o  = if_stall;
        bus.id_flush_o  = id_flush;
        bus.ex_flush_o  = ex_flush;
        bus.id_stall_o  = id_stall && !id_flush;
        bus.ex_stall_o  = ex_stall && !ex_flush;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
module tb_pipeline_ctrl;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(
        .RESET_ADDR      (32'h8000_0000),
        .TRAP_ALIGN_MASK (32'hFFFF_FFFC)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_ready_i      = 1'b1;
        bus.mem_busy_i      = 1'b0;
        bus.id_rs1_i        = 5'd0;
        bus.id_rs2_i        = 5'd0;
        bus.id_uses_rs1_i   = 1'b0;
        bus.id_uses_rs2_i   = 1'b0;
        bus.ex_valid_i      = 1'b0;
        bus.ex_rd_i         = 5'd0;
        bus.ex_is_load_i    = 1'b0;
        bus.ex_br_j_taken_i = 1'b0;
        bus.ex_br_j_addr_i  = 32'h0;
        bus.ex_exception_i  = 1'b0;
        bus.ex_is_mret_i    = 1'b0;
        bus.csr_mtvec_i     = 32'h0;
        bus.csr_mepc_i      = 32'h0;
    endtask

    // Control vector {trap_take, if_stall, id_stall, ex_stall, id_flush, ex_flush}
    function automatic logic [5:0] ctl();
        return {bus.trap_take_o, bus.if_stall_o, bus.id_stall_o, bus.ex_stall_o,
                bus.id_flush_o, bus.ex_flush_o};
    endfunction

    task automatic test_reset();
        logic [5:0] c;
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
        step();
        step();
        bus.ex_br_j_taken_i = 1'b1;
        bus.ex_br_j_addr_i  = 32'h8000_0500;
        bus.if_ready_i      = 1'b0;
        step();
        tests++;
        if (bus.state_o !== 2'd2) begin
            fails++;
            $display("FAIL reset_pre_state: got %0d want 2", bus.state_o);
        end
        #2 rst = 1'b1;
        idle_inputs();
        #1;
        tests++;
        if (bus.pc_o !== 32'h8000_0000 || bus.state_o !== 2'd0) begin
            fails++;
            $display("FAIL reset_async: pc %h state %0d want 80000000/0", bus.pc_o, bus.state_o);
        end
        step();
        rst = 1'b0;
        #1;
        c = ctl();
        tests++;
        if (c !== 6'b0 || bus.pc_o !== 32'h8000_0000 || bus.state_o !== 2'd0) begin
            fails++;
            $display("FAIL reset_release: ctl %b pc %h state %0d want 000000/80000000/0",
                     c, bus.pc_o, bus.state_o);
        end
    endtask

    task automatic test_straight();
        logic [31:0] exp_pc;
        exp_pc = 32'h8000_0000;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (ctl() !== 6'b0) begin
                fails++;
                $display("FAIL straight_ctl%0d: got %b want 000000", i, ctl());
            end
            step();
            exp_pc = exp_pc + 32'd4;
            tests++;
            if (bus.pc_o !== exp_pc) begin
                fails++;
                $display("FAIL straight_pc%0d: got %h want %h", i, bus.pc_o, exp_pc);
            end
        end
    endtask

    task automatic test_load_use();
        bus.ex_valid_i    = 1'b1;
        bus.ex_is_load_i  = 1'b1;
        bus.ex_rd_i       = 5'd5;
        bus.id_rs2_i      = 5'd5;
        bus.id_uses_rs2_i = 1'b1;
        #1;
        tests++;
        if (ctl() !== 6'b011001) begin
            fails++;
            $display("FAIL load_use_ctl: got %b want 011001", ctl());
        end
        step();
        tests++;
        if (bus.pc_o !== 32'h8000_0010) begin
            fails++;
            $display("FAIL load_use_pc_hold: got %h want 80000010", bus.pc_o);
        end
        // Load moved on; a bubble sits in EX now
        bus.ex_valid_i   = 1'b0;
        #1;
        tests++;
        if (ctl() !== 6'b0) begin
            fails++;
            $display("FAIL load_use_once: got %b want 000000", ctl());
        end
        step();
        bus.ex_valid_i = 1'b1;
        bus.ex_rd_i    = 5'd0;
        bus.id_rs2_i   = 5'd0;
        #1;
        tests++;
        if (ctl() !== 6'b0) begin
            fails++;
            $display("FAIL load_x0_ctl: got %b want 000000", ctl());
        end
        step();
        tests++;
        if (bus.pc_o !== 32'h8000_0018) begin
            fails++;
            $display("FAIL load_x0_pc: got %h want 80000018", bus.pc_o);
        end
        idle_inputs();
    endtask

    task automatic test_branch_ready();
        bus.ex_valid_i      = 1'b1;
        bus.ex_br_j_taken_i = 1'b1;
        bus.ex_br_j_addr_i  = 32'h8000_0100;
        #1;
        tests++;
        if (ctl() !== 6'b000011) begin
            fails++;
            $display("FAIL branch_ready_ctl: got %b want 000011", ctl());
        end
        step();
        idle_inputs();
        #1;
        tests++;
        if (bus.pc_o !== 32'h8000_0100 || ctl() !== 6'b0) begin
            fails++;
            $display("FAIL branch_ready_pc: pc %h ctl %b want 80000100/000000", bus.pc_o, ctl());
        end
    endtask

    task automatic test_branch_wait();
        bus.ex_valid_i      = 1'b1;
        bus.ex_br_j_taken_i = 1'b1;
        bus.ex_br_j_addr_i  = 32'h8000_0200;
        bus.if_ready_i      = 1'b0;
        #1;
        tests++;
        if (ctl() !== 6'b010011) begin
            fails++;
            $display("FAIL branch_wait_ctl: got %b want 010011", ctl());
        end
        step();
        bus.ex_valid_i      = 1'b0;
        bus.ex_br_j_taken_i = 1'b0;
        bus.ex_br_j_addr_i  = 32'h0;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++;
            if (bus.state_o !== 2'd2 || bus.pc_o !== 32'h8000_0100 || ctl() !== 6'b010010) begin
                fails++;
                $display("FAIL branch_wait_hold%0d: state %0d pc %h ctl %b want 2/80000100/010010",
                         i, bus.state_o, bus.pc_o, ctl());
            end
            step();
        end
        bus.if_ready_i = 1'b1;
        #1;
        tests++;
        if (ctl() !== 6'b000010) begin
            fails++;
            $display("FAIL branch_wait_drop: got %b want 000010", ctl());
        end
        step();
        tests++;
        if (bus.pc_o !== 32'h8000_0200 || bus.state_o !== 2'd0) begin
            fails++;
            $display("FAIL branch_wait_pc: pc %h state %0d want 80000200/0", bus.pc_o, bus.state_o);
        end
    endtask

    task automatic test_branch_over_load_use();
        bus.ex_valid_i      = 1'b1;
        bus.ex_is_load_i    = 1'b1;
        bus.ex_rd_i         = 5'd7;
        bus.id_rs1_i        = 5'd7;
        bus.id_uses_rs1_i   = 1'b1;
        bus.ex_br_j_taken_i = 1'b1;
        bus.ex_br_j_addr_i  = 32'hFFFF_FFFC;
        #1;
        tests++;
        if (ctl() !== 6'b000011) begin
            fails++;
            $display("FAIL branch_over_load_ctl: got %b want 000011", ctl());
        end
        step();
        idle_inputs();
        step();
        tests++;
        if (bus.pc_o !== 32'h0000_0000) begin
            fails++;
            $display("FAIL pc_wrap: got %h want 00000000", bus.pc_o);
        end
    endtask

    task automatic test_trap_busy();
        bus.mem_busy_i     = 1'b1;
        bus.ex_valid_i     = 1'b1;
        bus.ex_exception_i = 1'b1;
        bus.csr_mtvec_i    = 32'h8000_0043;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++;
            if (ctl() !== 6'b011100 || bus.state_o !== 2'd0) begin
                fails++;
                $display("FAIL trap_busy%0d: ctl %b state %0d want 011100/0", i, ctl(), bus.state_o);
            end
            step();
            tests++;
            if (bus.pc_o !== 32'h0000_0000) begin
                fails++;
                $display("FAIL trap_busy_pc%0d: got %h want 00000000", i, bus.pc_o);
            end
        end
        bus.mem_busy_i = 1'b0;
        #1;
        tests++;
        if (ctl() !== 6'b100011) begin
            fails++;
            $display("FAIL trap_take: got %b want 100011", ctl());
        end
        step();
        bus.ex_valid_i     = 1'b0;
        bus.ex_exception_i = 1'b0;
        #1;
        tests++;
        if (bus.state_o !== 2'd1 || ctl() !== 6'b000011) begin
            fails++;
            $display("FAIL trap_state: state %0d ctl %b want 1/000011", bus.state_o, ctl());
        end
        step();
        tests++;
        if (bus.pc_o !== 32'h8000_0040 || bus.state_o !== 2'd0) begin
            fails++;
            $display("FAIL trap_vector: pc %h state %0d want 80000040/0", bus.pc_o, bus.state_o);
        end
    endtask

    task automatic test_trap_pending();
        bus.ex_valid_i     = 1'b1;
        bus.ex_exception_i = 1'b1;
        bus.csr_mtvec_i    = 32'h8000_0800;
        bus.if_ready_i     = 1'b0;
        step();
        bus.ex_valid_i     = 1'b0;
        bus.ex_exception_i = 1'b0;
        step();
        #1;
        tests++;
        if (bus.state_o !== 2'd1 || ctl() !== 6'b010011) begin
            fails++;
            $display("FAIL trap_pend_hold: state %0d ctl %b want 1/010011", bus.state_o, ctl());
        end
        bus.if_ready_i = 1'b1;
        step();
        tests++;
        if (bus.pc_o !== 32'h8000_0800 || bus.state_o !== 2'd0) begin
            fails++;
            $display("FAIL trap_pend_exit: pc %h state %0d want 80000800/0", bus.pc_o, bus.state_o);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_straight();
        test_load_use();
        test_branch_ready();
        test_branch_wait();
        test_branch_over_load_use();
        test_trap_busy();
        test_trap_pending();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
